// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake, PSR flags, optional iterative multiply (ALU_SEQ_MUL_EN)
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [4:0]       psr
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // psr bit positions: {C,L,F,Z,N}
  localparam int PC = 4;
  localparam int PL = 3;
  localparam int PF = 2;
  localparam int PZ = 1;
  localparam int PN = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t state;
  state_t state_nx;

  logic accept;
  logic is_mul;

  // HOLD only frees up when write-back takes the current result, giving
  // back-to-back issue without a bubble.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             mul_done;

  assign is_mul   = (op == OP_MUL);
  // WIDTH shift-add steps, then one more cycle to move acc into result.
  assign mul_done = (cnt == CW'(WIDTH));
`else
  assign is_mul = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = is_mul ? BUSY : HOLD;
        end
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_nx = HOLD;
        end
`else
        state_nx = IDLE;
`endif
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            state_nx = is_mul ? BUSY : HOLD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               ovf_add;
  logic               ovf_sub;
  logic [SHW-1:0]     amt;
  logic [SHW-1:0]     mag;
  logic [WIDTH-1:0]   shl_res;
  logic [WIDTH-1:0]   res_c;
  logic               wr_c;
  logic [4:0]         psr_c;

  // single-cycle result, write enable and flag update for the op at the inputs
  always_comb begin
    sum     = {1'b0, dst} + {1'b0, src};
    diff    = {1'b0, dst} + {1'b0, ~src} + {{WIDTH{1'b0}}, 1'b1};
    ovf_add = (dst[WIDTH-1] == src[WIDTH-1]) && (sum[WIDTH-1] != dst[WIDTH-1]);
    ovf_sub = (dst[WIDTH-1] != src[WIDTH-1]) && (diff[WIDTH-1] != dst[WIDTH-1]);

    // shift amount is a signed field; magnitude fits SHW bits even for the most negative value
    amt = src[SHW-1:0];
    mag = amt[SHW-1] ? (~amt + SHW'(1)) : amt;
    if (mag >= SHW'(WIDTH)) begin
      shl_res = '0;
    end else if (amt[SHW-1]) begin
      shl_res = dst >> mag;
    end else begin
      shl_res = dst << mag;
    end

    res_c = '0;
    wr_c  = 1'b1;
    psr_c = psr;
    case (op)
      OP_ADD: begin
        res_c     = sum[WIDTH-1:0];
        psr_c[PC] = sum[WIDTH];
        psr_c[PF] = ovf_add;
        psr_c[PZ] = (sum[WIDTH-1:0] == '0);
      end
      OP_AND: begin
        res_c     = dst & src;
        psr_c[PZ] = ((dst & src) == '0);
      end
      OP_OR: begin
        res_c     = dst | src;
        psr_c[PZ] = ((dst | src) == '0);
      end
      OP_XOR: begin
        res_c     = dst ^ src;
        psr_c[PZ] = ((dst ^ src) == '0);
      end
      OP_SUB, OP_CMP: begin
        // carry-out of dst+~src+1 is the inverse of borrow
        res_c     = diff[WIDTH-1:0];
        psr_c[PC] = ~diff[WIDTH];
        psr_c[PL] = ~diff[WIDTH];
        psr_c[PF] = ovf_sub;
        psr_c[PZ] = (diff[WIDTH-1:0] == '0);
        psr_c[PN] = diff[WIDTH-1] ^ ovf_sub;
        wr_c      = (op != OP_CMP);
      end
      OP_SHL: begin
        res_c     = shl_res;
        psr_c[PZ] = (shl_res == '0);
      end
      OP_MUL: begin
        // only reaches the registers when the multiplier is not built
        res_c     = '0;
        wr_c      = 1'b0;
        psr_c[PZ] = 1'b1;
      end
      default: begin
        res_c = '0;
      end
    endcase
  end

  // result/flag registers and the shift-add multiplier; reset drops any op in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      wr_en  <= 1'b0;
      psr    <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        result <= res_c;
        wr_en  <= wr_c;
        psr    <= psr_c;
      end
`ifdef ALU_SEQ_MUL_EN
      if (accept && is_mul) begin
        mcand  <= dst;
        mplier <= src;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == BUSY) begin
        if (!mul_done) begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end else begin
          result  <= acc;
          wr_en   <= 1'b1;
          psr[PZ] <= (acc == '0);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

  localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 1;
`endif

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] src;
  logic [W-1:0] dst;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         wr_en;
  logic [4:0]   psr;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_res;
  logic         m_wr;
  logic [4:0]   m_psr;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src(src), .dst(dst), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .wr_en(wr_en), .psr(psr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the ALU rules, psr = {C,L,F,Z,N}
  function automatic void model_op(input logic [2:0] o, input logic [W-1:0] d, input logic [W-1:0] s);
    int ud, us, sd, ss, t, a;
    longint p;
    ud = int'(d);
    us = int'(s);
    sd = int'($signed(d));
    ss = int'($signed(s));
    m_wr = 1'b1;
    case (o)
      3'd0: begin
        t = ud + us;
        m_res = t[15:0];
        m_psr[4] = (t > 65535);
        m_psr[2] = ((sd + ss) > 32767) || ((sd + ss) < -32768);
        m_psr[1] = (m_res == 0);
      end
      3'd1: begin m_res = d & s; m_psr[1] = (m_res == 0); end
      3'd2: begin m_res = d | s; m_psr[1] = (m_res == 0); end
      3'd3: begin m_res = d ^ s; m_psr[1] = (m_res == 0); end
      3'd4, 3'd5: begin
        t = ud - us;
        m_res = t[15:0];
        m_psr[4] = (ud < us);
        m_psr[3] = (ud < us);
        m_psr[2] = ((sd - ss) > 32767) || ((sd - ss) < -32768);
        m_psr[1] = (ud == us);
        m_psr[0] = (sd < ss);
        m_wr = (o == 3'd4);
      end
      3'd6: begin
        a = int'(s[4:0]);
        if (a >= 16) a = a - 32;
        if (a >= 16 || a <= -16) m_res = '0;
        else if (a >= 0) m_res = d << a;
        else m_res = d >> (-a);
        m_psr[1] = (m_res == 0);
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        p = longint'(ud) * longint'(us);
        m_res = p[15:0];
        m_psr[1] = (m_res == 0);
`else
        p = 0;
        m_res = p[15:0];
        m_wr = 1'b0;
        m_psr[1] = 1'b1;
`endif
      end
    endcase
  endfunction

  // Issue one op from idle with out_ready=1; returns observed outputs and latency (-1 on timeout)
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d, input logic [W-1:0] s,
                       output logic [W-1:0] r, output logic w, output logic [4:0] f, output int lat);
    in_valid = 1'b1; op = o; dst = d; src = s;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); dst = 16'($urandom); src = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = result; w = wr_en; f = psr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; src = '0; dst = '0;
    m_psr = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (psr !== 5'b0) begin errors++; $display("FAIL reset_psr got=%b exp=00000", psr); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    logic [W-1:0] r; logic w; logic [4:0] f; int lat;
    model_op(3'd0, 16'h7FFF, 16'h0001);
    do_op(3'd0, 16'h7FFF, 16'h0001, r, w, f, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_ovf_latency got=%0d exp=1", lat); end
    checks++; if (r !== 16'h8000 || w !== 1'b1) begin errors++; $display("FAIL add_ovf_result got=%h/%b exp=8000/1", r, w); end
    checks++; if (f[4] !== 1'b0 || f[2] !== 1'b1 || f[1] !== 1'b0 || f !== m_psr) begin errors++; $display("FAIL add_ovf_psr got=%b exp=%b", f, m_psr); end
    model_op(3'd0, 16'hFFFF, 16'h0001);
    do_op(3'd0, 16'hFFFF, 16'h0001, r, w, f, lat);
    checks++; if (r !== 16'h0000 || f[4] !== 1'b1 || f[1] !== 1'b1 || f[2] !== 1'b0 || f !== m_psr) begin errors++; $display("FAIL add_wrap got=%h psr=%b exp=0000 psr=%b", r, f, m_psr); end
    model_op(3'd4, 16'h8000, 16'h0001);
    do_op(3'd4, 16'h8000, 16'h0001, r, w, f, lat);
    checks++; if (r !== 16'h7FFF || f[2] !== 1'b1 || f !== m_psr) begin errors++; $display("FAIL sub_ovf got=%h psr=%b exp=7fff psr=%b", r, f, m_psr); end
  endtask

  task automatic test_cmp();
    logic [W-1:0] r; logic w; logic [4:0] f; int lat;
    model_op(3'd5, 16'hFFFE, 16'h0001);
    do_op(3'd5, 16'hFFFE, 16'h0001, r, w, f, lat);
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL cmp_wr_en got=%b exp=0", w); end
    checks++; if (f[3] !== 1'b0 || f[0] !== 1'b1 || f[1] !== 1'b0 || f !== m_psr) begin errors++; $display("FAIL cmp_neg_psr got=%b exp=%b", f, m_psr); end
    model_op(3'd5, 16'h0005, 16'h0005);
    do_op(3'd5, 16'h0005, 16'h0005, r, w, f, lat);
    checks++; if (f[1] !== 1'b1 || f[0] !== 1'b0 || f[3] !== 1'b0 || f[4] !== 1'b0 || f !== m_psr) begin errors++; $display("FAIL cmp_eq_psr got=%b exp=%b", f, m_psr); end
  endtask

  task automatic test_shl();
    logic [W-1:0] r; logic w; logic [4:0] f; int lat;
    logic [W-1:0] amts [3];
    logic [W-1:0] exps [3];
    amts[0] = 16'h0004; amts[1] = 16'h001C; amts[2] = 16'h0010;
    exps[0] = 16'h0F00; exps[1] = 16'h000F; exps[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      model_op(3'd6, 16'h00F0, amts[i]);
      do_op(3'd6, 16'h00F0, amts[i], r, w, f, lat);
      checks++; if (r !== exps[i] || f !== m_psr || w !== 1'b1) begin errors++; $display("FAIL shl_%0d got=%h psr=%b exp=%h psr=%b", i, r, f, exps[i], m_psr); end
    end
  endtask

  task automatic test_random();
    logic [2:0] o; logic [W-1:0] d, s, r; logic w; logic [4:0] f; int lat;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      s = (i % 3 == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      model_op(o, d, s);
      do_op(o, d, s, r, w, f, lat);
      checks++; if (lat != ((o == 3'd7) ? MUL_LAT : 1)) begin errors++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, lat, (o == 3'd7) ? MUL_LAT : 1); end
      checks++; if (r !== m_res || w !== m_wr) begin errors++; $display("FAIL rand_result op=%0d d=%h s=%h got=%h/%b exp=%h/%b", o, d, s, r, w, m_res, m_wr); end
      checks++; if (f !== m_psr) begin errors++; $display("FAIL rand_psr op=%0d d=%h s=%h got=%b exp=%b", o, d, s, f, m_psr); end
    end
  endtask

  task automatic test_mul_hold();
    int n;
    logic [W-1:0] exp_mul;
    exp_mul = (MUL_LAT > 1) ? 16'h4E6F : 16'h0000;
    model_op(3'd7, 16'h0123, 16'h0045);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; dst = 16'h0123; src = 16'h0045;
    @(posedge clk); #1;
    op = 3'd0; dst = 16'h0001; src = 16'h0001;
    n = 1;
    while (!out_valid && n < 40) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready cycle=%0d got=%b exp=0", n, in_ready); end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", n, MUL_LAT); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || result !== exp_mul || result !== m_res || wr_en !== m_wr || in_ready !== 1'b0) begin errors++; $display("FAIL hold_stable_%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, result, wr_en, exp_mul, m_wr); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_queue got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [3];
    logic [W-1:0] ds [3], ss [3], er [3];
    logic [4:0]   ef [3];
    ops[0] = 3'd0; ops[1] = 3'd3; ops[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      ds[i] = 16'($urandom); ss[i] = 16'($urandom);
      model_op(ops[i], ds[i], ss[i]);
      er[i] = m_res; ef[i] = m_psr;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = ops[i]; dst = ds[i]; src = ss[i];
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== er[i] || psr !== ef[i]) begin errors++; $display("FAIL b2b_%0d got=%b/%b/%h/%b exp=1/1/%h/%b", i, out_valid, in_ready, result, psr, er[i], ef[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r; logic w; logic [4:0] f; int lat;
    model_op(3'd0, 16'hFFFF, 16'h0001);
    do_op(3'd0, 16'hFFFF, 16'h0001, r, w, f, lat);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; dst = 16'h1234; src = 16'h0101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || psr !== 5'b0 || result !== '0 || wr_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got=%b/%b/%h/%b/%b exp=0/00000/0000/0/1", out_valid, psr, result, wr_en, in_ready); end
    m_psr = '0;
    @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    model_op(3'd4, 16'h0003, 16'h0007);
    do_op(3'd4, 16'h0003, 16'h0007, r, w, f, lat);
    checks++; if (lat !== 1 || r !== m_res || w !== m_wr || f !== m_psr) begin errors++; $display("FAIL after_reset got=%0d/%h/%b/%b exp=1/%h/%b/%b", lat, r, w, f, m_res, m_wr, m_psr); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_cmp();
    test_shl();
    test_random();
    test_mul_hold();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
